fetch_pc_unit: RTL and testbench
================================

// Module: fetch_pc_unit
// PURPOSE
//  Fetch stage upstream of the immediate extender and decoder. Holds the PC and fetches from instruction memory
//  over a req/valid handshake with variable latency. Presents the instruction whose Instr[23:0] feeds the
//  extender. Consumes the extended immediate (ExtImm) back from the extender to compute branch targets.
//  Single clock; one instruction in flight; a memory-timeout watchdog raises a sticky fault.
// PARAMETERS
//  ResetVector  32'h0000_0000  PC loaded on reset; bits [1:0] must be 00
//  MaxWait      16             wait cycles allowed before fault; range 1..255; counter is 8 bits
// PORTS
//  clk           input   1   clock, rising edge
//  reset         input   1   synchronous, active-high reset
//  InstrReq      output  1   fetch request to instruction memory
//  InstrAddr     output  32  fetch address; equals PC; stable while InstrReq=1
//  InstrRdata    input   32  memory read data; sampled only when InstrValid=1 in FETCH
//  InstrValid    input   1   memory response strobe
//  Advance       input   1   datapath pulse: instruction held on InstrOut has executed
//  PCSrc         input   1   branch taken; qualified by Advance
//  ExtImm        input   32  branch offset from extender, in words, two's complement
//  InstrOut      output  32  latched instruction; [23:0] drives the extender Istr input
//  InstrOutValid output  1   InstrOut/PCOut are valid
//  PCOut         output  32  address of InstrOut
//  PCPlus8       output  32  PCOut+8, combinational; R15 read value
//  FetchErr      output  1   sticky memory-timeout fault
// BEHAVIOUR
//  States: IDLE, FETCH, HOLD, ERR. Reset is checked before all other logic at every edge.
//  Reset values:
//   - state=IDLE, PC=ResetVector, wait count=0.
//   - InstrReq=0, InstrOutValid=0, InstrOut=0, PCOut=0, FetchErr=0.
//   - PCPlus8 follows PCOut, so it reads 8 during reset.
//  IDLE: go to FETCH at the next edge. This gives exactly one dead cycle after reset deasserts.
//  FETCH (InstrReq=1, InstrAddr=PC):
//   - Edge with InstrValid=1: InstrOut<=InstrRdata, PCOut<=PC, InstrOutValid<=1, count<=0, go to HOLD.
//   - InstrValid may arrive in the first FETCH cycle. Minimum 1 cycle in FETCH.
//   - Edge with InstrValid=0: count<=count+1. If count+1==MaxWait: FetchErr<=1, go to ERR.
//  HOLD (InstrReq=0, InstrOutValid=1; outputs stable):
//   - Edge with Advance=1 and PCSrc=0: PC<=PCOut+4.
//   - Edge with Advance=1 and PCSrc=1: PC<=PCOut+8+(ExtImm<<2).
//   - On either Advance edge: InstrOutValid<=0, go to FETCH.
//   - Advance=0: stay in HOLD indefinitely.
//  ERR: InstrReq=0, InstrOutValid=0, FetchErr=1. Left only by reset.
//  Arithmetic: all PC math is 32-bit modulo 2^32, so wrap-around is silent. PC[1:0] is always 00.
//  Ignored inputs:
//   - InstrValid outside FETCH.
//   - PCSrc and ExtImm unless Advance=1 in HOLD.
//   - Advance outside HOLD.
//  Reset mid-operation: applies at the next edge in any state. Aborts an outstanding request,
//   clears the counter and clears FetchErr. A late InstrValid after reset is ignored in IDLE.
//  Throughput: at best one instruction per 2 cycles (FETCH, then HOLD with Advance=1).
// TESTING
//  1 Reset, then InstrValid=1 with 32'hE3A01005 in the first FETCH cycle:
//    -> InstrAddr=0; next cycle InstrOut=E3A01005, PCOut=0, PCPlus8=8, InstrOutValid=1.
//    Then Advance=1, PCSrc=0 -> next FETCH has InstrAddr=4.
//  2 Branch forward: PCOut=0x10, Advance=1, PCSrc=1, ExtImm=32'h3 -> InstrAddr=0x24.
//  3 Branch backward: PCOut=0x20, PCSrc=1, ExtImm=32'hFFFF_FFFE -> InstrAddr=0x20 (self-loop).
//  4 Wrap: PCOut=0xFFFF_FFFC, Advance=1, PCSrc=0 -> InstrAddr=0x0000_0000.
//  5 Timeout: MaxWait=16, InstrValid held 0
//    -> FetchErr=1 and InstrReq=0 after the 16th FETCH edge.
//    Later InstrValid and Advance have no effect; reset clears FetchErr.
//  6 Reset after 3 wait cycles, InstrValid=1 in the reset cycle
//    -> IDLE with no capture; InstrOutValid=0; next fetch at ResetVector; count restarts at 0.
//  Also: HOLD with Advance=0 for 10 cycles -> InstrOut/PCOut unchanged; PCSrc toggling has no effect.

Source files
------------

// File: rtl/fetch_pc_unit.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_pc_unit
//  Description : Fetch stage. Holds the PC, fetches one instruction at a time
//                over a variable-latency req/valid handshake, presents it to
//                the extender/decoder and computes the next PC from ExtImm.
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_pc_unit #(
    parameter logic [31:0] ResetVector = 32'h0000_0000,
    parameter int          MaxWait     = 16
) (
    input  logic        clk,
    input  logic        reset,
    output logic        InstrReq,
    output logic [31:0] InstrAddr,
    input  logic [31:0] InstrRdata,
    input  logic        InstrValid,
    input  logic        Advance,
    input  logic        PCSrc,
    input  logic [31:0] ExtImm,
    output logic [31:0] InstrOut,
    output logic        InstrOutValid,
    output logic [31:0] PCOut,
    output logic [31:0] PCPlus8,
    output logic        FetchErr
);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_FETCH = 2'd1;
    localparam logic [1:0] c_HOLD  = 2'd2;
    localparam logic [1:0] c_ERR   = 2'd3;

    localparam logic [7:0] c_MAX_WAIT = 8'(MaxWait);

    logic [1:0]  r_state;
    logic [31:0] r_pc;
    logic [7:0]  r_waitCnt;
    logic [31:0] r_instrOut;
    logic [31:0] r_pcOut;
    logic        r_instrOutValid;
    logic        r_fetchErr;

    logic [1:0]  w_stateNxt;
    logic [31:0] w_pcNxt;
    logic [7:0]  w_waitCntNxt;
    logic [31:0] w_instrOutNxt;
    logic [31:0] w_pcOutNxt;
    logic        w_instrOutValidNxt;
    logic        w_fetchErrNxt;
    logic [7:0]  w_waitCntInc;
    logic [31:0] w_branchOffset;

    assign w_waitCntInc   = r_waitCnt + 8'd1;
    // ExtImm counts words; the shift drops the top two bits as intended.
    assign w_branchOffset = ExtImm << 2;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state         <= c_IDLE;
            r_pc            <= ResetVector;
            r_waitCnt       <= 8'd0;
            r_instrOut      <= 32'd0;
            r_pcOut         <= 32'd0;
            r_instrOutValid <= 1'b0;
            r_fetchErr      <= 1'b0;
        end else begin
            r_state         <= w_stateNxt;
            r_pc            <= w_pcNxt;
            r_waitCnt       <= w_waitCntNxt;
            r_instrOut      <= w_instrOutNxt;
            r_pcOut         <= w_pcOutNxt;
            r_instrOutValid <= w_instrOutValidNxt;
            r_fetchErr      <= w_fetchErrNxt;
        end
    end

    always_comb begin
        w_stateNxt         = r_state;
        w_pcNxt            = r_pc;
        w_waitCntNxt       = r_waitCnt;
        w_instrOutNxt      = r_instrOut;
        w_pcOutNxt         = r_pcOut;
        w_instrOutValidNxt = r_instrOutValid;
        w_fetchErrNxt      = r_fetchErr;
        case (r_state)
            c_IDLE: begin
                w_stateNxt = c_FETCH;
            end
            c_FETCH: begin
                if (InstrValid) begin
                    w_instrOutNxt      = InstrRdata;
                    w_pcOutNxt         = r_pc;
                    w_instrOutValidNxt = 1'b1;
                    w_waitCntNxt       = 8'd0;
                    w_stateNxt         = c_HOLD;
                end else begin
                    w_waitCntNxt = w_waitCntInc;
                    if (w_waitCntInc == c_MAX_WAIT) begin
                        w_fetchErrNxt = 1'b1;
                        w_stateNxt    = c_ERR;
                    end
                end
            end
            c_HOLD: begin
                if (Advance) begin
                    // Branch target is relative to PC+8 (pipeline-visible R15).
                    w_pcNxt            = PCSrc ? (r_pcOut + 32'd8 + w_branchOffset)
                                               : (r_pcOut + 32'd4);
                    w_instrOutValidNxt = 1'b0;
                    w_stateNxt         = c_FETCH;
                end
            end
            c_ERR: begin
                w_stateNxt = c_ERR;
            end
            default: begin
                w_stateNxt = c_IDLE;
            end
        endcase
    end

    assign InstrReq      = (r_state == c_FETCH);
    assign InstrAddr     = r_pc;
    assign InstrOut      = r_instrOut;
    assign InstrOutValid = r_instrOutValid;
    assign PCOut         = r_pcOut;
    assign PCPlus8       = r_pcOut + 32'd8;
    assign FetchErr      = r_fetchErr;

endmodule
`default_nettype wire

// File: tb/tb_fetch_pc_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fetch_pc_unit
//  Description : Self-checking bench for fetch_pc_unit with a response
//                scoreboard and a bench-side PC model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_pc_unit;

    logic        clk;
    logic        reset;
    logic        InstrReq;
    logic [31:0] InstrAddr;
    logic [31:0] InstrRdata;
    logic        InstrValid;
    logic        Advance;
    logic        PCSrc;
    logic [31:0] ExtImm;
    logic [31:0] InstrOut;
    logic        InstrOutValid;
    logic [31:0] PCOut;
    logic [31:0] PCPlus8;
    logic        FetchErr;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } exp_t;

    exp_t        r_sbQ[$];
    int          nChecks = 0;
    int          nErrors = 0;
    logic [31:0] expPc;
    logic [31:0] heldPc;
    logic [31:0] heldInstr;

    fetch_pc_unit #(
        .ResetVector(32'h0000_0000),
        .MaxWait    (16)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .InstrReq     (InstrReq),
        .InstrAddr    (InstrAddr),
        .InstrRdata   (InstrRdata),
        .InstrValid   (InstrValid),
        .Advance      (Advance),
        .PCSrc        (PCSrc),
        .ExtImm       (ExtImm),
        .InstrOut     (InstrOut),
        .InstrOutValid(InstrOutValid),
        .PCOut        (PCOut),
        .PCPlus8      (PCPlus8),
        .FetchErr     (FetchErr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nErrors++;
            $display("FAIL %s actual=%h expected=%h", tag, act, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic doFetch(input logic [31:0] data, input int lat);
        exp_t e;
        int   n;
        n = 0;
        while (!InstrReq && n < 20) begin
            tick();
            n++;
        end
        chk("req_seen", {31'd0, InstrReq}, 32'd1);
        chk("fetch_addr", InstrAddr, expPc);
        for (int i = 0; i < lat; i++) begin
            InstrValid = 1'b0;
            tick();
        end
        if (lat > 0) chk("req_held", {31'd0, InstrReq}, 32'd1);
        InstrValid = 1'b1;
        InstrRdata = data;
        r_sbQ.push_back('{instr: data, pc: expPc});
        tick();
        InstrValid = 1'b0;
        InstrRdata = 32'hDEAD_BEEF;
        e = r_sbQ.pop_front();
        chk("instr_out", InstrOut, e.instr);
        chk("pc_out", PCOut, e.pc);
        chk("pc_plus8", PCPlus8, e.pc + 32'd8);
        chk("out_valid", {31'd0, InstrOutValid}, 32'd1);
        chk("req_drop", {31'd0, InstrReq}, 32'd0);
        heldPc    = e.pc;
        heldInstr = e.instr;
    endtask

    task automatic doAdvance(input logic taken, input logic [31:0] imm);
        Advance = 1'b1;
        PCSrc   = taken;
        ExtImm  = imm;
        expPc   = taken ? (heldPc + 32'd8 + (imm << 2)) : (heldPc + 32'd4);
        tick();
        Advance = 1'b0;
        PCSrc   = 1'b0;
        ExtImm  = 32'd0;
        chk("adv_valid", {31'd0, InstrOutValid}, 32'd0);
        chk("adv_req", {31'd0, InstrReq}, 32'd1);
        chk("next_addr", InstrAddr, expPc);
    endtask

    initial begin
        reset      = 1'b1;
        InstrRdata = 32'd0;
        InstrValid = 1'b0;
        Advance    = 1'b0;
        PCSrc      = 1'b0;
        ExtImm     = 32'd0;
        expPc      = 32'd0;
        heldPc     = 32'd0;
        heldInstr  = 32'd0;
        tick();
        tick();
        chk("rst_req", {31'd0, InstrReq}, 32'd0);
        chk("rst_valid", {31'd0, InstrOutValid}, 32'd0);
        chk("rst_instr", InstrOut, 32'd0);
        chk("rst_pcout", PCOut, 32'd0);
        chk("rst_pcplus8", PCPlus8, 32'd8);
        chk("rst_err", {31'd0, FetchErr}, 32'd0);

        // Dead IDLE cycle, then first fetch answered immediately
        reset = 1'b0;
        tick();
        chk("first_req", {31'd0, InstrReq}, 32'd1);
        doFetch(32'hE3A0_1005, 0);
        doAdvance(1'b0, 32'd0);

        // Sequential run up to PCOut=0x10, with Advance during FETCH ignored
        Advance = 1'b1;
        PCSrc   = 1'b1;
        ExtImm  = 32'h100;
        tick();
        Advance = 1'b0;
        PCSrc   = 1'b0;
        ExtImm  = 32'd0;
        chk("fetch_adv_ign", InstrAddr, 32'h4);
        for (int k = 0; k < 3; k++) begin
            doFetch(32'h1000_0000 + 32'(k), k);
            doAdvance(1'b0, 32'd0);
        end
        doFetch(32'hEA00_0003, 1);
        chk("pc_at_10", PCOut, 32'h10);

        // Branch forward, backward, self-loop, to top of memory, then wrap
        doAdvance(1'b1, 32'h0000_0003);
        chk("br_fwd", InstrAddr, 32'h24);
        doFetch(32'hEAFF_FFFD, 2);
        doAdvance(1'b1, 32'hFFFF_FFFD);
        doFetch(32'hEAFF_FFFE, 0);
        chk("pc_at_20", PCOut, 32'h20);
        doAdvance(1'b1, 32'hFFFF_FFFE);
        chk("br_self", InstrAddr, 32'h20);
        doFetch(32'hEAFF_FFFE, 3);
        doAdvance(1'b1, 32'hFFFF_FFF5);
        doFetch(32'hE1A0_0000, 1);
        chk("pc_top", PCOut, 32'hFFFF_FFFC);

        // Long HOLD: PCSrc/ExtImm/InstrValid toggling without Advance
        for (int k = 0; k < 10; k++) begin
            PCSrc      = k[0];
            ExtImm     = 32'(k * 7);
            InstrValid = k[1];
            InstrRdata = 32'h5555_0000 + 32'(k);
            tick();
        end
        PCSrc      = 1'b0;
        InstrValid = 1'b0;
        chk("hold_instr", InstrOut, heldInstr);
        chk("hold_pc", PCOut, 32'hFFFF_FFFC);
        chk("hold_valid", {31'd0, InstrOutValid}, 32'd1);
        doAdvance(1'b0, 32'd0);
        chk("wrap", InstrAddr, 32'h0000_0000);

        // Reset after 3 wait cycles with a late InstrValid in the reset cycle
        for (int k = 0; k < 3; k++) tick();
        reset      = 1'b1;
        InstrValid = 1'b1;
        InstrRdata = 32'hBAD0_BAD0;
        tick();
        reset      = 1'b0;
        InstrValid = 1'b1;
        chk("rst_mid_valid", {31'd0, InstrOutValid}, 32'd0);
        chk("rst_mid_req", {31'd0, InstrReq}, 32'd0);
        chk("rst_mid_instr", InstrOut, 32'd0);
        tick();
        InstrValid = 1'b0;
        chk("idle_no_capture", {31'd0, InstrOutValid}, 32'd0);
        expPc = 32'd0;
        // 15 empty waits only fit if the counter restarted
        doFetch(32'hE3A0_2007, 15);
        chk("no_err_15", {31'd0, FetchErr}, 32'd0);
        doAdvance(1'b0, 32'd0);

        // Timeout: 16 FETCH edges without a response
        for (int k = 0; k < 15; k++) tick();
        chk("pre_to_err", {31'd0, FetchErr}, 32'd0);
        chk("pre_to_req", {31'd0, InstrReq}, 32'd1);
        tick();
        chk("to_err", {31'd0, FetchErr}, 32'd1);
        chk("to_req", {31'd0, InstrReq}, 32'd0);
        InstrValid = 1'b1;
        Advance    = 1'b1;
        for (int k = 0; k < 3; k++) tick();
        InstrValid = 1'b0;
        Advance    = 1'b0;
        chk("err_sticky", {31'd0, FetchErr}, 32'd1);
        chk("err_valid", {31'd0, InstrOutValid}, 32'd0);
        chk("err_req", {31'd0, InstrReq}, 32'd0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("err_clear", {31'd0, FetchErr}, 32'd0);
        tick();
        chk("restart_req", {31'd0, InstrReq}, 32'd1);
        chk("restart_addr", InstrAddr, 32'h0);

        chk("sb_empty", 32'(r_sbQ.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", nChecks, nErrors);
        $finish;
    end

endmodule
`default_nettype wire
